// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the elastic stage registers between CPU pipeline stages:
// per-boundary payload widths, NOP payloads and the skid-register state encoding.
package cpu_pipe_pkg;

  localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  // IF/ID: pc + inst; ID/EX: aluop, alusel, reg1, reg2, wd, wreg; EX/MEM and MEM/WB: wd, wreg, wdata
  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 81;
  localparam int EX_MEM_W = 38;
  localparam int MEM_WB_W = 38;

  localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = {ZeroWord, ZeroWord};
  localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = {EXE_NOP_OP, EXE_RES_NOP, ZeroWord, ZeroWord,
                                                NOPRegAddr, WriteDisable};
  localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = {NOPRegAddr, WriteDisable, ZeroWord};
  localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = {NOPRegAddr, WriteDisable, ZeroWord};

  // Encoding equals the number of held entries, so level is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with one skid entry and synchronous flush.
// All outputs decode from registers; out_ready only steers next-state logic.
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int                   PAYLOAD_W   = ID_EX_W,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           level
);

  skid_state_t          state, state_next;
  logic [PAYLOAD_W-1:0] main_data, main_next;
  logic [PAYLOAD_W-1:0] skid_data, skid_next;
  logic                 in_fire, out_fire;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign level     = state;
  assign out_data  = main_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_next = state;
    main_next  = main_data;
    skid_next  = skid_data;
    if (flush) begin
      // Any concurrent in_fire is dropped; a concurrent out_fire was already consumed.
      state_next = ST_EMPTY;
      main_next  = NOP_PAYLOAD;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_next = ST_ONE;
            main_next  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire) begin
            state_next = ST_FULL;
            skid_next  = in_data;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
            main_next  = NOP_PAYLOAD;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_next = ST_ONE;
            main_next  = skid_data;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          main_next  = NOP_PAYLOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_data <= NOP_PAYLOAD;
    end else begin
      state     <= state_next;
      main_data <= main_next;
    end
  end

  // Skid contents are only meaningful in ST_FULL, so they need no reset.
  always_ff @(posedge clk) begin
    skid_data <= skid_next;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized checks of pipe_skid_reg against hand-derived values
// and a small FIFO model.
module tb_pipe_skid_reg;

  localparam int             W   = 16;
  localparam logic [W-1:0]   NOP = 16'hA5A5;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   level;

  int compared   = 0;
  int mismatched = 0;

  pipe_skid_reg #(.PAYLOAD_W(W), .NOP_PAYLOAD(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    tick();
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    compared++; if (level !== 2'd0) begin mismatched++; $display("FAIL reset_level: got %0d expected 0", level); end
    compared++; if (out_data !== NOP) begin mismatched++; $display("FAIL reset_out_data: got %h expected %h", out_data, NOP); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      tick();
      compared++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin mismatched++; $display("FAIL stream_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, W'(i)); end
      compared++; if (level !== 2'd1) begin mismatched++; $display("FAIL stream_level[%0d]: got %0d expected 1", i, level); end
    end
    in_valid = 1'b0;
    tick();
    compared++; if (out_valid !== 1'b0 || out_data !== NOP || level !== 2'd0) begin mismatched++; $display("FAIL stream_drain: got v=%b d=%h l=%0d expected v=0 d=%h l=0", out_valid, out_data, level, NOP); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = 16'h00AA; out_ready = 1'b1;
    tick();
    in_data = 16'h00BB; out_ready = 1'b0;
    tick();
    compared++; if (level !== 2'd2 || in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_full: got l=%0d rdy=%b expected l=2 rdy=0", level, in_ready); end
    in_data = 16'h00CC;
    for (int i = 0; i < 3; i++) begin
      compared++; if (out_data !== 16'h00AA || out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_stall_hold[%0d]: got v=%b d=%h expected v=1 d=00aa", i, out_valid, out_data); end
      tick();
    end
    compared++; if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h00AA) begin mismatched++; $display("FAIL bp_stall_end: got l=%0d rdy=%b d=%h expected l=2 rdy=0 d=00aa", level, in_ready, out_data); end
    out_ready = 1'b1;
    tick();
    compared++; if (out_data !== 16'h00BB || level !== 2'd1 || in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_b: got d=%h l=%0d rdy=%b expected d=00bb l=1 rdy=1", out_data, level, in_ready); end
    tick();
    compared++; if (out_data !== 16'h00CC || out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_release_c: got v=%b d=%h expected v=1 d=00cc", out_valid, out_data); end
    in_valid = 1'b0;
    tick();
    compared++; if (level !== 2'd0) begin mismatched++; $display("FAIL bp_drain: got %0d expected 0", level); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = 16'h0111; out_ready = 1'b0;
    tick();
    in_data = 16'h0222;
    tick();
    compared++; if (level !== 2'd2) begin mismatched++; $display("FAIL flush_prefill: got %0d expected 2", level); end
    flush = 1'b1; in_data = 16'h0DEF;
    tick();
    compared++; if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1) begin mismatched++; $display("FAIL flush_full: got l=%0d v=%b d=%h rdy=%b expected l=0 v=0 d=%h rdy=1", level, out_valid, out_data, in_ready, NOP); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    compared++; if (out_valid !== 1'b0 || out_data !== NOP) begin mismatched++; $display("FAIL flush_dropped: got v=%b d=%h expected v=0 d=%h", out_valid, out_data, NOP); end
  endtask

  task automatic test_simultaneous();
    in_valid = 1'b1; in_data = 16'h0D0D; out_ready = 1'b1;
    tick();
    in_data = 16'h0E0E;
    tick();
    compared++; if (out_data !== 16'h0E0E || level !== 2'd1) begin mismatched++; $display("FAIL simul_replace: got d=%h l=%0d expected d=0e0e l=1", out_data, level); end
    in_data = 16'h0F0F; rst = 1'b1;
    tick();
    compared++; if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1) begin mismatched++; $display("FAIL simul_reset: got l=%0d v=%b d=%h rdy=%b expected l=0 v=0 d=%h rdy=1", level, out_valid, out_data, in_ready, NOP); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] exp_data, prev_data;
    logic         prev_stall, rdy_a, rdy_b, m_in_fire, m_out_fire;
    int           errs;
    errs = 0;
    q.delete();
    prev_stall = 1'b0;
    prev_data  = NOP;
    for (int c = 0; c < 10000; c++) begin
      exp_data = (q.size() != 0) ? q[0] : NOP;
      compared++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() != 2) ||
          level !== 2'(q.size()) || out_data !== exp_data) begin
        mismatched++;
        if (errs++ < 10) $display("FAIL rand_state[%0d]: got v=%b rdy=%b l=%0d d=%h expected l=%0d d=%h", c, out_valid, in_ready, level, out_data, q.size(), exp_data);
      end
      if (prev_stall) begin
        compared++;
        if (out_data !== prev_data || out_valid !== 1'b1) begin
          mismatched++;
          if (errs++ < 10) $display("FAIL rand_stall[%0d]: got v=%b d=%h expected v=1 d=%h", c, out_valid, out_data, prev_data);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      #1;
      rdy_a = in_ready;
      out_ready = ~out_ready;
      #1;
      rdy_b = in_ready;
      out_ready = ~out_ready;
      #1;
      compared++;
      if (rdy_a !== rdy_b) begin
        mismatched++;
        if (errs++ < 10) $display("FAIL rand_ready_indep[%0d]: got %b expected %b", c, rdy_b, rdy_a);
      end
      m_in_fire  = in_valid && (q.size() != 2);
      m_out_fire = out_ready && (q.size() != 0);
      prev_stall = (q.size() != 0) && !out_ready && !flush;
      prev_data  = exp_data;
      if (flush) q.delete();
      else begin
        if (m_out_fire) void'(q.pop_front());
        if (m_in_fire) q.push_back(in_data);
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline-stage register for the CPU core, replacing the fixed, always-advancing stage latches between IF/ID, ID/EX, EX/MEM and MEM/WB. It carries an opaque payload with a valid/ready handshake, absorbs one cycle of downstream back-pressure in a skid entry, and supports a synchronous flush that squashes in-flight instructions into NOPs. Upstream stage drives the `in_*` side; downstream stage consumes the `out_*` side.

## Interface
- PAYLOAD_W, 81, payload width in bits (ID/EX: aluop 8 + alusel 3 + reg1 32 + reg2 32 + wd 5 + wreg 1).
- NOP_PAYLOAD, all-zero, payload value presented while empty or after reset/flush. Each stage passes its own NOP encoding here.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  block can accept; registered, never combinationally dependent on `out_ready`.
- in_data  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  `out_data` holds a live instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  PAYLOAD_W  payload to downstream; registered.
- level  out  2  entries held: 0, 1 or 2.

## Operation
- Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives `out_data`) and one skid register.
- States: EMPTY (level 0), ONE (main valid), FULL (main and skid valid).
- EMPTY: in_fire -> ONE, main <= in_data.
- ONE, in_fire & out_fire -> ONE, main <= in_data.
- ONE, in_fire & !out_ready -> FULL, skid <= in_data.
- ONE, out_fire & !in_fire -> EMPTY, main <= NOP_PAYLOAD.
- ONE, no fire -> hold.
- FULL: in_ready = 0. out_fire -> ONE, main <= skid. No out_fire -> hold.
- Decoding: in_ready = (state != FULL); out_valid = (state != EMPTY); level follows state.
- Priority: rst > flush > handshake.
- Flush: next state EMPTY, main <= NOP_PAYLOAD. Any simultaneous in_fire is dropped. A simultaneous out_fire still counts as consumed downstream.
- Ordering: payloads leave in arrival order, none duplicated or lost except on flush.
- Payload is not interpreted; no arithmetic on data.

## Timing
- Reset values: state EMPTY, out_valid 0, in_ready 1, level 0, out_data = NOP_PAYLOAD; skid contents don't-care.
- Latency: in_fire at edge N gives out_valid = 1 with that payload after edge N, i.e. 1 cycle.
- Throughput: 1 payload/cycle sustained while out_ready = 1.
- Back-pressure: `in_ready` drops the cycle after the first unaccepted transfer, so at most 1 extra payload is absorbed. It rises the cycle after out_fire in FULL.
- Stall: when out_ready is low, out_data and out_valid stay stable, with no glitches or changes until out_fire.
- Mid-operation reset or flush takes effect at the same edge regardless of state.
- Combinational paths: `out_ready` reaches state only, never `in_ready` or `out_data` within the cycle.

## Structure
- Shared package cpu_pipe_pkg holds:
  - per-boundary payload widths (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W);
  - NOP payload constants built from the existing EXE_NOP_OP, EXE_RES_NOP, NOPRegAddr and WriteDisable definitions;
  - the 2-bit state encoding.
- Single flat module, no sub-module. Instantiate once per stage boundary. The hazard unit drives flush; the downstream stage's stall logic drives out_ready.

## Test plan
- Reset: assert rst 2 cycles with in_valid = 1 -> out_valid 0, in_ready 1, level 0, out_data = NOP_PAYLOAD.
- Streaming: out_ready = 1, payloads 0x01..0x10 one per cycle -> each appears 1 cycle later, in order, level never exceeds 1.
- Back-pressure:
  - Stimulus: send A, B, C back-to-back, out_ready low from cycle 1 to 4.
  - Required: out_data holds A, in_ready = 0 after B is skidded, level = 2, C stays upstream.
  - Release: A, B, C then emerge on consecutive cycles.
- Flush in FULL with in_fire attempted -> next cycle level 0, out_valid 0, out_data = NOP_PAYLOAD; the in_data presented during flush never appears.
- Simultaneous in_fire & out_fire in ONE:
  - Main replaced, level stays 1.
  - rst asserted the same cycle -> EMPTY and reset values win.
- Random valid/ready: 10k cycles against a scoreboard FIFO model -> order preserved, no loss or duplication, out_data constant during stall, in_ready independent of same-cycle out_ready.
